// File: rtl/replica_sweep_seq.sv
// ---------------------------------------------------------------------------
// replica_sweep_seq
//   Per-chain command sequencer for the replica-exchange annealer. Each
//   iteration issues one full sweep to the node array:
//     RAND(1) -> DIST(DIST_LAT) -> MTR(MTR_LAT) -> REPL(REPL_LAT) -> EXCH(EX_LAT)
//   Each working state pulses its *_run strobe on its first cycle and then
//   holds for its latency through one shared down-counter.
//
//   Optional feature (macro SWEEP_SNAPSHOT_EN): after every snap_int-th
//   iteration, a SNAP phase holds distance_shift high for NODE_NUM cycles and
//   pulses snap_req on entry. Without the macro, SNAP is unreachable and
//   distance_shift is tied low.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start, abort      run request / sticky stop request (acted on at EXCH end)
//   iter_num          iterations to run (0 = finish immediately)
//   mode_fix/mode_val hold opt_sel at mode_val (clamped) instead of rotating
//   busy, done        run in progress / 1-cycle end-of-run pulse
//   iter_cnt          completed iterations (saturating)
//   opt_sel           opt mode for current iteration
//   *_run             phase strobes to the node array
//   exchange_bank     replica pairing parity, toggles per iteration
//   distance_shift    total-distance shift phase level
//   snap_int, snap_req  snapshot interval / snapshot entry pulse (macro only)
// ---------------------------------------------------------------------------
module replica_sweep_seq #(
  parameter int NODE_NUM  = 32,
  parameter int ITER_W    = 32,
  parameter int OPT_MODES = 2,
  parameter int DIST_LAT  = 6,
  parameter int MTR_LAT   = 4,
  parameter int REPL_LAT  = 4,
  parameter int EX_LAT    = 130,
  localparam int SELW     = (OPT_MODES > 1) ? $clog2(OPT_MODES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iter_num,
  input  logic              mode_fix,
  input  logic [SELW-1:0]   mode_val,
`ifdef SWEEP_SNAPSHOT_EN
  input  logic [ITER_W-1:0] snap_int,
  output logic              snap_req,
`endif
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [SELW-1:0]   opt_sel,
  output logic              random_run,
  output logic              distance_run,
  output logic              metropolis_run,
  output logic              replica_run,
  output logic              exchange_run,
  output logic              exchange_bank,
  output logic              distance_shift
);

  localparam int M1   = (DIST_LAT > MTR_LAT) ? DIST_LAT : MTR_LAT;
  localparam int M2   = (M1 > REPL_LAT) ? M1 : REPL_LAT;
  localparam int M3   = (M2 > EX_LAT) ? M2 : EX_LAT;
  localparam int MAXL = (M3 > NODE_NUM) ? M3 : NODE_NUM;
  localparam int CW   = (MAXL > 2) ? $clog2(MAXL) : 1;

  localparam logic [SELW:0]   MODES_L   = (SELW+1)'(OPT_MODES);
  localparam logic [SELW-1:0] LAST_MODE = SELW'(OPT_MODES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RAND, S_DIST, S_MTR, S_REPL, S_EXCH, S_SNAP, S_FIN
  } state_t;

  state_t            state, nxt;
  logic [CW-1:0]     cnt;
  logic              ent;        // first cycle of the current state
  logic              abort_q;
  logic [ITER_W-1:0] iter_max;
  logic [ITER_W-1:0] cnt_inc;
  logic [SELW-1:0]   mode_clamp;
  logic              start_ok, phase_end, exch_end, last_iter, snap_due;

  // Cycles to hold each state, minus one (the entry cycle)
  function automatic logic [CW-1:0] lat_m1(state_t s);
    case (s)
      S_DIST:  lat_m1 = CW'(DIST_LAT - 1);
      S_MTR:   lat_m1 = CW'(MTR_LAT - 1);
      S_REPL:  lat_m1 = CW'(REPL_LAT - 1);
      S_EXCH:  lat_m1 = CW'(EX_LAT - 1);
      S_SNAP:  lat_m1 = CW'(NODE_NUM - 1);
      default: lat_m1 = '0;
    endcase
  endfunction

  assign start_ok   = start && (state == S_IDLE);
  assign phase_end  = (cnt == '0);
  assign exch_end   = (state == S_EXCH) && phase_end;
  assign cnt_inc    = (iter_cnt == '1) ? iter_cnt : iter_cnt + 1'b1;
  assign last_iter  = (cnt_inc == iter_max) || abort_q;
  assign mode_clamp = ({1'b0, mode_val} >= MODES_L) ? LAST_MODE : mode_val;

`ifdef SWEEP_SNAPSHOT_EN
  // Iterations since the last snapshot; equivalent to iter_cnt % snap_int
  // while snap_int is held stable for the run.
  logic [ITER_W-1:0] snap_ctr;
  assign snap_due       = (snap_int != '0) && ((snap_ctr + 1'b1) == snap_int);
  assign distance_shift = (state == S_SNAP);
  assign snap_req       = ent && (state == S_SNAP);
`else
  assign snap_due       = 1'b0;
  assign distance_shift = 1'b0;
`endif

  assign busy           = (state != S_IDLE) && (state != S_FIN);
  assign random_run     = ent && (state == S_RAND);
  assign distance_run   = ent && (state == S_DIST);
  assign metropolis_run = ent && (state == S_MTR);
  assign replica_run    = ent && (state == S_REPL);
  assign exchange_run   = ent && (state == S_EXCH);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = (iter_num == '0) ? S_FIN : S_RAND;
      S_RAND: if (phase_end) nxt = S_DIST;
      S_DIST: if (phase_end) nxt = S_MTR;
      S_MTR:  if (phase_end) nxt = S_REPL;
      S_REPL: if (phase_end) nxt = S_EXCH;
      S_EXCH: if (phase_end) begin
        if (snap_due)       nxt = S_SNAP;
        else if (last_iter) nxt = S_FIN;
        else                nxt = S_RAND;
      end
      // iter_cnt already advanced when SNAP was entered
      S_SNAP: if (phase_end) nxt = ((iter_cnt == iter_max) || abort_q) ? S_FIN : S_RAND;
      S_FIN:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      ent           <= 1'b0;
      cnt           <= '0;
      done          <= 1'b0;
      abort_q       <= 1'b0;
      iter_max      <= '0;
      iter_cnt      <= '0;
      opt_sel       <= '0;
      exchange_bank <= 1'b0;
`ifdef SWEEP_SNAPSHOT_EN
      snap_ctr      <= '0;
`endif
    end else begin
      state <= nxt;
      ent   <= (nxt != state);
      done  <= (state == S_FIN);
      if (nxt != state)   cnt <= lat_m1(nxt);
      else if (cnt != '0) cnt <= cnt - 1'b1;

      if (start_ok) begin
        iter_max      <= iter_num;
        iter_cnt      <= '0;
        exchange_bank <= 1'b0;
        opt_sel       <= mode_fix ? mode_clamp : '0;
        abort_q       <= abort;   // start wins, abort still takes effect after iter 1
`ifdef SWEEP_SNAPSHOT_EN
        snap_ctr      <= '0;
`endif
      end else begin
        if (state == S_FIN)                      abort_q <= 1'b0;
        else if (abort && (state != S_IDLE))     abort_q <= 1'b1;
        if (exch_end) begin
          iter_cnt      <= cnt_inc;
          exchange_bank <= ~exchange_bank;
          if (mode_fix)               opt_sel <= mode_clamp;
          else if (opt_sel >= LAST_MODE) opt_sel <= '0;
          else                        opt_sel <= opt_sel + 1'b1;
`ifdef SWEEP_SNAPSHOT_EN
          snap_ctr <= snap_due ? '0 : snap_ctr + 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_replica_sweep_seq.sv
// Scoreboard bench for replica_sweep_seq: stimulus pushes expected strobe
// events (cycle, kind, iter_cnt, opt_sel, bank, busy); a negedge monitor pops
// and compares whenever the DUT raises a strobe or done.
module tb_replica_sweep_seq;
  localparam int PER = 1 + 6 + 4 + 4 + 130;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, mode_fix = 1'b0;
  logic [0:0]  mode_val = 1'b0;
  logic [31:0] iter_num = '0;
  logic        busy, done, random_run, distance_run, metropolis_run, replica_run;
  logic        exchange_run, exchange_bank, distance_shift;
  logic [31:0] iter_cnt;
  logic [0:0]  opt_sel;
  logic        snap_bit;
`ifdef SWEEP_SNAPSHOT_EN
  logic [31:0] snap_int = '0;
  logic        snap_req;
  assign snap_bit = snap_req;
`else
  assign snap_bit = 1'b0;
`endif

  replica_sweep_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .iter_num(iter_num),
    .mode_fix(mode_fix), .mode_val(mode_val),
`ifdef SWEEP_SNAPSHOT_EN
    .snap_int(snap_int), .snap_req(snap_req),
`endif
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .opt_sel(opt_sel),
    .random_run(random_run), .distance_run(distance_run), .metropolis_run(metropolis_run),
    .replica_run(replica_run), .exchange_run(exchange_run), .exchange_bank(exchange_bank),
    .distance_shift(distance_shift)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         c;
    logic [6:0] m;   // {snap, done, exch, repl, mtr, dist, rand}
    int         ic;
    int         os;
    int         bk;
    logic       by;
  } ev_t;

  ev_t q[$];
  int  checks = 0, failures = 0;
  int  ev_limit = -1, ev_pushed = 0;
  int  shift_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int kind, input int ic, input int os, input int bk);
    ev_t e;
    if (ev_limit >= 0 && ev_pushed >= ev_limit) return;
    e.c = c; e.m = 7'(1 << kind); e.ic = ic; e.os = os; e.bk = bk; e.by = (kind != 5);
    q.push_back(e);
    ev_pushed++;
  endtask

  // Expected events for a run of m iterations whose start is sampled at edge k
  task automatic exp_run(input int k, input int m, input int fix, input int fv, input int si);
    int cur;
    cur = k;
    ev_pushed = 0;
    for (int i = 0; i < m; i++) begin
      int os;
      os = fix ? fv : i % 2;
      push(cur,      0, i, os, i & 1);
      push(cur + 1,  1, i, os, i & 1);
      push(cur + 7,  2, i, os, i & 1);
      push(cur + 11, 3, i, os, i & 1);
      push(cur + 15, 4, i, os, i & 1);
      cur += PER;
      if (si != 0 && (i + 1) % si == 0) begin
        push(cur, 6, i + 1, fix ? fv : (i + 1) % 2, (i + 1) & 1);
        cur += 32;
      end
    end
    push(cur + 1, 5, m, fix ? fv : m % 2, m & 1);
  endtask

  task automatic run(input int n, input bit ab, input int m, input int fix, input int fv,
                     input int si, output int k);
    @(posedge clk); #1;
    k = cyc + 1;
    exp_run(k, m, fix, fv, si);
    iter_num = n; start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (q.size() != 0 && t < budget) begin @(posedge clk); #1; t++; end
    chk("drain_queue_empty", q.size(), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe/done must match the next expected event
  always @(negedge clk) begin
    logic [6:0] m;
    ev_t e;
    m = {snap_bit, done, exchange_run, replica_run, metropolis_run, distance_run, random_run};
    if (distance_shift) shift_cnt++;
    if (m != '0) begin
      if (q.size() == 0) chk("unexpected_output", m, 0);
      else begin
        e = q.pop_front();
        chk("ev_cycle", cyc, e.c);
        chk("ev_kind", m, e.m);
        chk("ev_iter_cnt", iter_cnt, e.ic);
        chk("ev_opt_sel", opt_sel, e.os);
        chk("ev_bank", exchange_bank, e.bk);
        chk("ev_busy", busy, e.by);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iter_cnt", iter_cnt, 0);
    chk("rst_opt_sel", opt_sel, 0);
    chk("rst_bank", exchange_bank, 0);
    chk("rst_shift", distance_shift, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: three rotating iterations
    run(3, 1'b0, 3, 0, 0, 0, k);
    chk("t1_busy_after_start", busy, 1);
    drain(3 * PER + 20);
    chk("t1_iter_cnt", iter_cnt, 3);
    chk("t1_busy_end", busy, 0);

    // 2: zero iterations -> immediate done
    run(0, 1'b0, 0, 0, 0, 0, k);
    drain(20);
    chk("t2_iter_cnt", iter_cnt, 0);

    // 3: abort during DIST of iteration 2
    run(10, 1'b0, 2, 0, 0, 0, k);
    wait_cyc(k + PER + 2);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drain(3 * PER);
    chk("t3_iter_cnt", iter_cnt, 2);

    // 4: reset during MTR of iteration 1, then a fresh run
    ev_limit = 3;
    run(5, 1'b0, 5, 0, 0, 0, k);
    wait_cyc(k + 8);
    reset = 1'b0;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_iter_cnt", iter_cnt, 0);
    chk("t4_strobes", {done, random_run, distance_run, metropolis_run, replica_run, exchange_run}, 0);
    @(posedge clk); #1 reset = 1'b1;
    ev_limit = -1;
    repeat (20) @(posedge clk);
    #1;
    chk("t4_no_stray_events", q.size(), 0);
    q.delete();
    run(1, 1'b0, 1, 0, 0, 0, k);
    drain(PER + 20);
    chk("t4_fresh_iter_cnt", iter_cnt, 1);

    // 5a: start while busy is ignored (iter_num=5 not latched)
    run(2, 1'b0, 2, 0, 0, 0, k);
    wait_cyc(k + 20);
    iter_num = 5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    drain(2 * PER + 20);
    chk("t5_busy_start_ignored", iter_cnt, 2);

    // 5b: start+abort together with fixed mode 1 -> exactly one iteration
    mode_fix = 1'b1; mode_val = 1'b1;
    run(5, 1'b1, 1, 1, 1, 0, k);
    drain(PER + 20);
    chk("t5_start_abort_iter_cnt", iter_cnt, 1);
    mode_fix = 1'b0; mode_val = 1'b0;

`ifdef SWEEP_SNAPSHOT_EN
    // 6: snapshot after iterations 2 and 4
    snap_int = 2;
    shift_cnt = 0;
    run(4, 1'b0, 4, 0, 0, 2, k);
    drain(4 * PER + 100);
    chk("t6_shift_cycles", shift_cnt, 64);
    chk("t6_iter_cnt", iter_cnt, 4);
    snap_int = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
